// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction tester session controller.
package reaction_pkg;

    localparam int RES_W    = 14;
    localparam int SUM_W    = RES_W + 4;
    localparam int MS_CNT_W = 16;

    localparam logic [RES_W-1:0] DISP_MAX = RES_W'(9999);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARM      = 3'd1,
        S_WAIT_RES = 3'd2,
        S_GAP      = 3'd3,
        S_DIVIDE   = 3'd4,
        S_REPORT   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        SEL_LIVE  = 2'd0,
        SEL_BEST  = 2'd1,
        SEL_WORST = 2'd2,
        SEL_AVG   = 2'd3
    } disp_sel_t;

    // Anything above the four-digit display range is pinned to 9999.
    function automatic logic [RES_W-1:0] clamp_result(input logic [RES_W-1:0] value);
        return (value > DISP_MAX) ? DISP_MAX : value;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per cycle, start/done handshake.
module seq_divider #(
    parameter int DIVIDEND_W = 18,
    parameter int DIVISOR_W  = 4,
    parameter int QUOT_W     = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic [QUOT_W-1:0]     quotient,
    output logic                  done
);

    localparam int CNT_W = $clog2(DIVIDEND_W + 1);

    logic [DIVIDEND_W-1:0] quo_q;
    logic [DIVISOR_W-1:0]  rem_q;
    logic [DIVISOR_W-1:0]  div_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [DIVISOR_W:0]    shifted;
    logic [DIVISOR_W:0]    diff;
    logic                  fits;

    // The partial remainder is always below the divisor, so a successful
    // subtraction never sets the top bit; that bit doubles as the borrow.
    assign shifted  = {rem_q, quo_q[DIVIDEND_W-1]};
    assign diff     = shifted - {1'b0, div_q};
    assign fits     = ~diff[DIVISOR_W];
    assign quotient = quo_q[QUOT_W-1:0];

    // Load on start, then shift in one quotient bit per cycle until the count runs out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quo_q <= '0;
            rem_q <= '0;
            div_q <= '0;
            cnt_q <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                quo_q <= dividend;
                rem_q <= '0;
                div_q <= divisor;
                cnt_q <= CNT_W'(DIVIDEND_W);
            end else if (cnt_q != '0) begin
                rem_q <= fits ? diff[DIVISOR_W-1:0] : shifted[DIVISOR_W-1:0];
                quo_q <= {quo_q[DIVIDEND_W-2:0], fits};
                cnt_q <= cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/trial_sequencer.sv
// Session controller: runs a fixed number of reaction trials, then reports best/worst/average.
module trial_sequencer
    import reaction_pkg::*;
#(
    parameter int N_TRIALS   = 5,
    parameter int GAP_MS     = 1000,
    parameter int TIMEOUT_MS = 5000,
    parameter int SHOW_MS    = 2000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_session_start,
    input  logic             i_ms_tick,
    input  logic             i_result_valid,
    input  logic [RES_W-1:0] i_result_ms,
    input  logic             i_result_err,
    output logic             o_trial_start,
    output logic [3:0]       o_trial_idx,
    output logic [RES_W-1:0] o_disp_value,
    output logic [1:0]       o_disp_sel,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_no_valid
);

    localparam logic [MS_CNT_W-1:0] TIMEOUT_LAST = MS_CNT_W'(TIMEOUT_MS - 1);
    localparam logic [MS_CNT_W-1:0] GAP_LAST     = MS_CNT_W'(GAP_MS - 1);
    localparam logic [MS_CNT_W-1:0] SHOW_LAST    = MS_CNT_W'(SHOW_MS - 1);
    localparam logic [3:0]          LAST_TRIAL   = 4'(N_TRIALS);

    state_t              state, next_state;
    disp_sel_t           sel;
    logic                start_q, start_edge;
    logic [MS_CNT_W-1:0] ms_cnt;
    logic [3:0]          trial_idx, vcount;
    logic [SUM_W-1:0]    sum;
    logic [RES_W-1:0]    best, worst, live_val, avg, clamped, div_quot;
    logic                no_valid, div_done;
    logic                session_begin, take_result, next_trial, div_start, show_advance;

    assign start_edge = i_session_start & ~start_q;
    assign clamped    = clamp_result(i_result_ms);

    seq_divider #(
        .DIVIDEND_W(SUM_W),
        .DIVISOR_W (4),
        .QUOT_W    (RES_W)
    ) u_divider (
        .clk     (clk),
        .rst     (rst),
        .start   (div_start),
        .dividend(sum),
        .divisor (vcount),
        .quotient(div_quot),
        .done    (div_done)
    );

    // State register; reset aborts any session straight back to idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decisions, datapath strobes and the output decode.
    always_comb begin
        next_state    = state;
        session_begin = 1'b0;
        take_result   = 1'b0;
        next_trial    = 1'b0;
        div_start     = 1'b0;
        show_advance  = 1'b0;
        o_trial_start = 1'b0;
        o_busy        = 1'b0;
        o_done        = 1'b0;
        o_trial_idx   = 4'd0;
        o_disp_sel    = SEL_LIVE;
        o_disp_value  = live_val;
        o_no_valid    = no_valid;
        case (state)
            S_IDLE: begin
                if (start_edge) begin
                    session_begin = 1'b1;
                    next_state    = S_ARM;
                end
            end
            S_ARM: begin
                o_trial_start = 1'b1;
                next_state    = S_WAIT_RES;
            end
            S_WAIT_RES: begin
                if (i_result_valid) begin
                    take_result = 1'b1;
                    next_state  = S_GAP;
                end else if (i_ms_tick && ms_cnt == TIMEOUT_LAST) begin
                    next_state = S_GAP;
                end
            end
            S_GAP: begin
                if (i_ms_tick && ms_cnt == GAP_LAST) begin
                    if (trial_idx == LAST_TRIAL) begin
                        next_state = S_DIVIDE;
                        div_start  = (vcount != 4'd0);
                    end else begin
                        next_trial = 1'b1;
                        next_state = S_ARM;
                    end
                end
            end
            S_DIVIDE: begin
                if (vcount == 4'd0 || div_done) begin
                    next_state = S_REPORT;
                end
            end
            S_REPORT: begin
                o_done     = 1'b1;
                o_disp_sel = sel;
                case (sel)
                    SEL_BEST:  o_disp_value = no_valid ? '0 : best;
                    SEL_WORST: o_disp_value = no_valid ? '0 : worst;
                    default:   o_disp_value = avg;
                endcase
                if (start_edge) begin
                    session_begin = 1'b1;
                    next_state    = S_ARM;
                end else if (i_ms_tick && ms_cnt == SHOW_LAST) begin
                    show_advance = 1'b1;
                end
            end
            default: next_state = S_IDLE;
        endcase
        if (state == S_ARM || state == S_WAIT_RES || state == S_GAP || state == S_DIVIDE) begin
            o_busy      = 1'b1;
            o_trial_idx = trial_idx;
        end
    end

    // Session accumulators, the shared ms counter and the report rotation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q   <= 1'b0;
            ms_cnt    <= '0;
            trial_idx <= 4'd0;
            vcount    <= 4'd0;
            sum       <= '0;
            best      <= '1;
            worst     <= '0;
            live_val  <= '0;
            avg       <= '0;
            no_valid  <= 1'b0;
            sel       <= SEL_LIVE;
        end else begin
            start_q <= i_session_start;
            if (next_state != state || show_advance) begin
                ms_cnt <= '0;
            end else if (i_ms_tick) begin
                ms_cnt <= ms_cnt + 1'b1;
            end
            if (session_begin) begin
                trial_idx <= 4'd1;
                vcount    <= 4'd0;
                sum       <= '0;
                best      <= '1;
                worst     <= '0;
                live_val  <= '0;
                avg       <= '0;
                no_valid  <= 1'b0;
            end
            if (next_trial) begin
                trial_idx <= trial_idx + 4'd1;
            end
            if (take_result && !i_result_err) begin
                sum      <= sum + {4'd0, clamped};
                vcount   <= vcount + 4'd1;
                live_val <= clamped;
                if (clamped < best) begin
                    best <= clamped;
                end
                if (clamped > worst) begin
                    worst <= clamped;
                end
            end
            if (state == S_DIVIDE && next_state == S_REPORT) begin
                avg      <= (vcount == 4'd0) ? '0 : div_quot;
                no_valid <= (vcount == 4'd0);
                sel      <= SEL_BEST;
            end
            if (show_advance) begin
                case (sel)
                    SEL_BEST:  sel <= SEL_WORST;
                    SEL_WORST: sel <= SEL_AVG;
                    default:   sel <= SEL_BEST;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_trial_sequencer.sv
// Randomised session bench with a scoreboard fed by a trial-level reference model.
module tb_trial_sequencer;
    import reaction_pkg::*;

    localparam int N_TRIALS   = 5;
    localparam int GAP_MS     = 4;
    localparam int TIMEOUT_MS = 12;
    localparam int SHOW_MS    = 3;
    localparam int K_OK       = 0;
    localparam int K_ERR      = 1;
    localparam int K_TIMEOUT  = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             i_session_start = 1'b0;
    logic             i_ms_tick = 1'b0;
    logic             i_result_valid = 1'b0;
    logic [RES_W-1:0] i_result_ms = '0;
    logic             i_result_err = 1'b0;
    logic             o_trial_start;
    logic [3:0]       o_trial_idx;
    logic [RES_W-1:0] o_disp_value;
    logic [1:0]       o_disp_sel;
    logic             o_busy;
    logic             o_done;
    logic             o_no_valid;

    typedef struct {
        int best;
        int worst;
        int avg;
        bit no_valid;
    } report_t;

    report_t report_q[$];
    int      trial_q[$];
    int      plan_kind[N_TRIALS];
    int      plan_val[N_TRIALS];
    int      n_checks = 0;
    int      n_pass = 0;
    int      sel_changes = 0;

    trial_sequencer #(
        .N_TRIALS  (N_TRIALS),
        .GAP_MS    (GAP_MS),
        .TIMEOUT_MS(TIMEOUT_MS),
        .SHOW_MS   (SHOW_MS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_session_start(i_session_start),
        .i_ms_tick      (i_ms_tick),
        .i_result_valid (i_result_valid),
        .i_result_ms    (i_result_ms),
        .i_result_err   (i_result_err),
        .o_trial_start  (o_trial_start),
        .o_trial_idx    (o_trial_idx),
        .o_disp_value   (o_disp_value),
        .o_disp_sel     (o_disp_sel),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_no_valid     (o_no_valid)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic recordFail(input string name);
        n_checks++;
        $display("[TB] FAIL %s: bounded wait expired at %0t", name, $time);
    endtask

    function automatic int clampMs(input int v);
        return (v > 9999) ? 9999 : v;
    endfunction

    // Expected report derived from the trial plan: min/max/floor-mean of valid trials.
    function automatic report_t modelSession();
        report_t r;
        int sum = 0;
        int cnt = 0;
        int lo = 0;
        int hi = 0;
        for (int i = 0; i < N_TRIALS; i++) begin
            if (plan_kind[i] == K_OK) begin
                int v = clampMs(plan_val[i]);
                if (cnt == 0 || v < lo) lo = v;
                if (cnt == 0 || v > hi) hi = v;
                sum += v;
                cnt++;
            end
        end
        if (cnt == 0) r = '{0, 0, 0, 1'b1};
        else          r = '{lo, hi, sum / cnt, 1'b0};
        return r;
    endfunction

    function automatic int expectedShown(input report_t r, input int s);
        if (s == 1) return r.best;
        if (s == 2) return r.worst;
        return r.avg;
    endfunction

    // Free-running, randomly spaced millisecond ticks.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            i_ms_tick = ($urandom_range(0, 1) == 1);
        end
    end

    // Monitor: pops expected trial numbers on each start pulse and checks the report rotation.
    initial begin
        bit      prev_done = 1'b0;
        int      prev_sel = 0;
        int      exp_sel = 1;
        report_t cur = '{0, 0, 0, 1'b0};
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_done = 1'b0;
                continue;
            end
            if (o_trial_start) begin
                if (trial_q.size() == 0) recordFail("unexpected_trial_start");
                else checkOutput("trial_idx", 32'(o_trial_idx), 32'(trial_q.pop_front()));
            end
            if (o_done && !prev_done) begin
                if (report_q.size() == 0) begin
                    recordFail("unexpected_report");
                end else begin
                    cur = report_q.pop_front();
                    exp_sel = 1;
                    sel_changes = 0;
                    checkOutput("report_sel", 32'(o_disp_sel), 32'(exp_sel));
                    checkOutput("report_value", 32'(o_disp_value), 32'(expectedShown(cur, exp_sel)));
                    checkOutput("no_valid", 32'(o_no_valid), 32'(cur.no_valid));
                    checkOutput("busy_in_report", 32'(o_busy), 32'd0);
                end
            end else if (o_done && 32'(o_disp_sel) != prev_sel) begin
                exp_sel = (exp_sel == 3) ? 1 : exp_sel + 1;
                sel_changes++;
                checkOutput("report_sel", 32'(o_disp_sel), 32'(exp_sel));
                checkOutput("report_value", 32'(o_disp_value), 32'(expectedShown(cur, exp_sel)));
            end
            prev_done = o_done;
            prev_sel = 32'(o_disp_sel);
        end
    end

    task automatic pressStart();
        @(posedge clk);
        #1 i_session_start = 1'b1;
        @(posedge clk);
        #1 i_session_start = 1'b0;
    endtask

    task automatic waitTrialStart(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (o_trial_start) begin
                ok = 1'b1;
                return;
            end
        end
        recordFail("wait_trial_start");
    endtask

    // Plays one whole session from the current plan, acting as the reaction FSM.
    task automatic applyStimulus();
        bit ok;
        int live = 0;
        int d;
        report_q.push_back(modelSession());
        for (int i = 1; i <= N_TRIALS; i++) trial_q.push_back(i);
        pressStart();
        for (int i = 0; i < N_TRIALS; i++) begin
            waitTrialStart(ok);
            if (!ok) return;
            if (plan_kind[i] != K_TIMEOUT) begin
                d = $urandom_range(1, TIMEOUT_MS - 2);
                repeat (d) @(posedge clk);
                #1;
                i_result_valid = 1'b1;
                i_result_err   = (plan_kind[i] == K_ERR);
                i_result_ms    = RES_W'(plan_val[i]);
                @(posedge clk);
                #1;
                i_result_valid = 1'b0;
                i_result_err   = 1'b0;
                if (plan_kind[i] == K_OK) live = clampMs(plan_val[i]);
                checkOutput("live_value", 32'(o_disp_value), 32'(live));
                if ($urandom_range(0, 1) == 1) begin
                    @(posedge clk);
                    #1;
                    i_result_valid  = 1'b1;
                    i_result_ms     = RES_W'($urandom_range(0, 12000));
                    i_session_start = 1'b1;
                    @(posedge clk);
                    #1;
                    i_result_valid  = 1'b0;
                    i_session_start = 1'b0;
                end
            end
        end
        ok = 1'b0;
        for (int c = 0; c < 2000 && !ok; c++) begin
            @(negedge clk);
            ok = o_done;
        end
        if (!ok) begin
            recordFail("wait_report");
            return;
        end
        repeat (40) @(negedge clk);
        checkOutput("report_cycling", 32'(sel_changes >= 3), 32'd1);
    endtask

    task automatic setPlan(input int k0, input int v0, input int k1, input int v1, input int k2, input int v2,
                           input int k3, input int v3, input int k4, input int v4);
        plan_kind = '{k0, k1, k2, k3, k4};
        plan_val  = '{v0, v1, v2, v3, v4};
    endtask

    initial begin
        bit ok;
        int starts;
        $display("[TB] trial_sequencer bench starting");
        repeat (3) @(posedge clk);
        #2;
        checkOutput("reset_trial_start", 32'(o_trial_start), 32'd0);
        checkOutput("reset_trial_idx", 32'(o_trial_idx), 32'd0);
        checkOutput("reset_disp_value", 32'(o_disp_value), 32'd0);
        checkOutput("reset_disp_sel", 32'(o_disp_sel), 32'd0);
        checkOutput("reset_busy", 32'(o_busy), 32'd0);
        checkOutput("reset_done", 32'(o_done), 32'd0);
        checkOutput("reset_no_valid", 32'(o_no_valid), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Abort a session while it waits for the first result.
        trial_q.push_back(1);
        pressStart();
        waitTrialStart(ok);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("abort_busy", 32'(o_busy), 32'd0);
        checkOutput("abort_trial_idx", 32'(o_trial_idx), 32'd0);
        checkOutput("abort_trial_start", 32'(o_trial_start), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        starts = 0;
        repeat (10) begin
            @(negedge clk);
            if (o_trial_start) starts++;
        end
        checkOutput("abort_no_restart", 32'(starts), 32'd0);
        checkOutput("abort_idle_busy", 32'(o_busy), 32'd0);

        setPlan(K_OK, 250, K_OK, 310, K_OK, 199, K_OK, 400, K_OK, 275);
        applyStimulus();
        setPlan(K_OK, 300, K_ERR, 50, K_OK, 301, K_ERR, 60, K_OK, 305);
        applyStimulus();
        setPlan(K_TIMEOUT, 0, K_TIMEOUT, 0, K_TIMEOUT, 0, K_TIMEOUT, 0, K_TIMEOUT, 0);
        applyStimulus();
        setPlan(K_OK, 12000, K_OK, 100, K_OK, 200, K_OK, 300, K_OK, 400);
        applyStimulus();
        for (int s = 0; s < 6; s++) begin
            for (int i = 0; i < N_TRIALS; i++) begin
                int r = $urandom_range(0, 99);
                plan_kind[i] = (r < 70) ? K_OK : (r < 85) ? K_ERR : K_TIMEOUT;
                plan_val[i]  = $urandom_range(0, 12000);
            end
            applyStimulus();
        end

        checkOutput("queues_drained", 32'(report_q.size() + trial_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/trial_sequencer.md
Name: trial_sequencer

Overview:
Session controller for the reaction tester. It runs N_TRIALS back-to-back measurements by pulsing the reaction FSM's start input and collecting each response_time result. It then computes best, worst and average over the valid trials and sequences these onto the BCD/segment display path. It sits between the debounced start button and the FSM, and ahead of binToBCD.

Parameters:
N_TRIALS, 5, trials per session (2..15)
GAP_MS, 1000, idle gap between trials in ms
TIMEOUT_MS, 5000, max wait for a result before the trial is marked an error
SHOW_MS, 2000, dwell per report item in REPORT
RES_W, 14, result width in ms units

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
i_session_start  in  1  debounced start button, level; rising edge detected internally
i_ms_tick  in  1  one-cycle pulse every 1 ms
i_result_valid  in  1  one-cycle pulse from FSM: trial finished
i_result_ms  in  RES_W  response time, valid with i_result_valid
i_result_err  in  1  false start / no response, valid with i_result_valid
o_trial_start  out  1  one-cycle pulse to FSM start
o_trial_idx  out  4  current trial number, 1-based; 0 when idle
o_disp_value  out  RES_W  value to display
o_disp_sel  out  2  0=live, 1=best, 2=worst, 3=average
o_busy  out  1  session in progress
o_done  out  1  high in REPORT
o_no_valid  out  1  session ended with zero valid trials

Behaviour:
- Reset (async, rst=1): state IDLE. All outputs 0. Accumulators cleared; best=all-ones, worst=0.
- States: IDLE, ARM, WAIT_RES, GAP, DIVIDE, REPORT.
- IDLE: on rising edge of i_session_start, clear sum/count/best/worst and set trial_idx=1 -> ARM.
- ARM: drive o_trial_start=1 for exactly one cycle, clear the ms counter -> WAIT_RES.
- WAIT_RES:
  - On i_result_valid with err=0: sum+=result, vcount+=1, update best/worst, o_disp_value=result.
  - On i_result_valid with err=1: count the trial, no accumulation.
  - Either result -> GAP, ms counter cleared.
  - Counting ms ticks up to TIMEOUT_MS with no result: error trial -> GAP.
- GAP: after GAP_MS ticks, if trial_idx==N_TRIALS -> DIVIDE, else trial_idx+=1 -> ARM.
- DIVIDE: start seq_divider(sum, vcount). On its done -> REPORT.
  - If vcount==0, skip the divide: avg=0, o_no_valid=1.
  - Latency is RES_W+4 cycles max.
- REPORT: o_done=1, o_busy=0.
  - o_disp_sel cycles 1->2->3->1 every SHOW_MS ticks; o_disp_value follows the selected value.
  - If o_no_valid, best and worst show 0.
  - Rising edge of i_session_start starts a new session (same action as from IDLE).
- o_busy=1 in ARM, WAIT_RES, GAP and DIVIDE. o_disp_sel=0 outside REPORT.
- Width rules:
  - Results are clamped to 9999 before use.
  - sum is RES_W+4 bits (no overflow for 15×9999).
  - Average is truncated (floor).
- Ignored inputs:
  - i_result_valid outside WAIT_RES is ignored.
  - Start edges outside IDLE/REPORT are ignored.
- Simultaneous events:
  - i_ms_tick and i_result_valid in the same cycle: the result wins; no timeout.
  - Timeout reached and result in the same cycle: treated as the result.
- Reset mid-session aborts immediately to IDLE. No o_trial_start glitch.

Decomposition:
- Package reaction_pkg holds: state enum (3 bits), display-select codes, DISP_MAX=9999, and RES_W.
- Sub-module seq_divider is natural.
  - Restoring, one quotient bit per cycle, start/done handshake.
  - Dividend RES_W+4 bits, divisor 4 bits, quotient RES_W bits.

Test Plan:
- Reset mid-WAIT_RES -> all outputs 0, state IDLE, no o_trial_start for 10 cycles after release.
- N_TRIALS=5, results 250,310,199,400,275 -> REPORT shows best=199, worst=400, avg=286 (1434/5 floored).
- Trials 2 and 4 with err=1, others 300,301,305 -> avg=302, best=300, worst=305, o_no_valid=0.
- No result for TIMEOUT_MS on every trial -> each advances after 5000 ticks; REPORT shows o_no_valid=1 and avg=0.
- Result 12000 -> clamped to 9999 for best/worst/sum; i_result_valid in GAP -> ignored, sum unchanged.
- Start edge during GAP -> ignored; start edge in REPORT -> o_trial_start one cycle later, trial_idx=1, accumulators cleared.
